// File: rtl/hazard_bubble_ctrl_pkg.sv
// Shared CPU pipeline constants for the control-hazard bubble controller.
package hazard_bubble_ctrl_pkg;

    // Hazard channel indices, highest priority first.
    localparam int CH_EXC = 0;   // eret / syscall
    localparam int CH_BR  = 1;   // jump / jal / jalr / all branches

    // Default number of bubbles injected per accepted hazard.
    localparam int BUBBLE_DEPTH = 3;

endpackage : hazard_bubble_ctrl_pkg

// File: rtl/hazard_bubble_ctrl_bubble_chan.sv
// One bubble down-counter: clear beats load, load beats hold, hold beats decrement.
module bubble_chan
    import hazard_bubble_ctrl_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_hold,
    input  logic             i_dec,
    input  logic [CNT_W-1:0] i_depth,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Counter update; decrement only ever happens from a non-zero value so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_depth;
        end else if (i_hold) begin
            r_cnt <= r_cnt;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;

endmodule : bubble_chan

// File: rtl/hazard_bubble_ctrl.sv
// Control-hazard bubble controller: prioritised per-channel bubble counters,
// request-drop flags and a saturating bubble-cycle performance counter.
module hazard_bubble_ctrl
    import hazard_bubble_ctrl_pkg::*;
#(
    parameter int                        NUM_CH = 2,
    parameter int                        CNT_W  = 2,
    parameter logic [NUM_CH*CNT_W-1:0]   DEPTHS = {2'(BUBBLE_DEPTH), 2'(BUBBLE_DEPTH)},
    parameter int                        PERF_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req,
    input  logic                     stall,
    input  logic                     perf_clr,
    output logic [NUM_CH*CNT_W-1:0]  bubble_cnt,
    output logic [NUM_CH-1:0]        bubble_act,
    output logic                     bubble_any,
    output logic [NUM_CH-1:0]        req_drop,
    output logic [PERF_W-1:0]        perf_bubbles
);

    logic [CNT_W-1:0]  w_cnt [NUM_CH];
    logic [NUM_CH-1:0] w_accept;
    logic [NUM_CH-1:0] w_clear;
    logic [NUM_CH-1:0] r_req_drop;
    logic [PERF_W-1:0] r_perf;
    logic              w_any;

    // Acceptance and squash: walk channels from highest priority; a request is taken only
    // when its depth is non-zero, no counter at or above its priority is active, and no
    // higher-priority request was already taken. Everything below a taken request is cleared.
    always_comb begin : accept_logic
        logic v_busy;
        logic v_taken;
        w_accept = '0;
        w_clear  = '0;
        v_busy   = 1'b0;
        v_taken  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            v_busy     = v_busy | (w_cnt[i] != '0);
            w_clear[i] = v_taken;
            if (req[i] && (DEPTHS[i*CNT_W +: CNT_W] != '0) && !v_busy && !v_taken) begin
                w_accept[i] = 1'b1;
                v_taken     = 1'b1;
            end else begin
                w_accept[i] = 1'b0;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_chan
            bubble_chan #(
                .CNT_W (CNT_W)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .i_clear (w_clear[g]),
                .i_load  (w_accept[g]),
                .i_hold  (stall),
                .i_dec   (~stall),
                .i_depth (DEPTHS[g*CNT_W +: CNT_W]),
                .o_cnt   (w_cnt[g])
            );
            assign bubble_cnt[g*CNT_W +: CNT_W] = w_cnt[g];
            assign bubble_act[g]                = (w_cnt[g] != '0);
        end
    endgenerate

    assign w_any      = |bubble_act;
    assign bubble_any = w_any;

    // Drop flags: one-cycle pulse for every request that was not accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_drop <= '0;
        end else begin
            r_req_drop <= req & ~w_accept;
        end
    end

    // Bubble-cycle performance counter: clear wins, then saturating increment on unstalled bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf <= '0;
        end else if (perf_clr) begin
            r_perf <= '0;
        end else if (w_any && !stall && (r_perf != '1)) begin
            r_perf <= r_perf + PERF_W'(1);
        end else begin
            r_perf <= r_perf;
        end
    end

    assign req_drop     = r_req_drop;
    assign perf_bubbles = r_perf;

endmodule : hazard_bubble_ctrl

// File: tb/tb_hazard_bubble_ctrl.sv
// Scoreboard bench: two DUT instances (default depths, and channel 1 disabled with a
// 2-bit perf counter) share stimulus; a reference model pushes expectations, a monitor pops.
module tb_hazard_bubble_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic       stall = 1'b0;
    logic       perf_clr = 1'b0;

    logic [3:0]  cnt1, cnt2;
    logic [1:0]  act1, act2, drop1, drop2;
    logic        any1, any2;
    logic [15:0] perf1;
    logic [1:0]  perf2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_bubble_ctrl u_dut1 (
        .clk(clk), .rst(rst), .req(req), .stall(stall), .perf_clr(perf_clr),
        .bubble_cnt(cnt1), .bubble_act(act1), .bubble_any(any1),
        .req_drop(drop1), .perf_bubbles(perf1)
    );

    hazard_bubble_ctrl #(.NUM_CH(2), .CNT_W(2), .DEPTHS({2'd0, 2'd3}), .PERF_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .req(req), .stall(stall), .perf_clr(perf_clr),
        .bubble_cnt(cnt2), .bubble_act(act2), .bubble_any(any2),
        .req_drop(drop2), .perf_bubbles(perf2)
    );

    typedef struct packed {
        logic [3:0]  cnt;
        logic [1:0]  drop;
        logic [15:0] perf;
    } st_t;

    typedef struct packed {
        st_t a;
        st_t b;
    } pair_t;

    pair_t q[$];
    st_t   m1, m2;

    // Reference: winner is the lowest requesting channel with non-zero depth whose own
    // and higher-priority counters sum to zero; everything below the winner is flushed.
    function automatic st_t step(st_t s, logic [1:0] rq, logic st, logic clr,
                                 int d0, int d1, int pmax);
        int c[2];
        int d[2];
        int nc[2];
        int win;
        int sum;
        st_t n;
        c[0] = int'(s.cnt[1:0]);
        c[1] = int'(s.cnt[3:2]);
        d[0] = d0;
        d[1] = d1;
        win  = -1;
        sum  = 0;
        for (int i = 0; i < 2; i++) begin
            sum += c[i];
            if (win < 0 && rq[i] && d[i] != 0 && sum == 0) win = i;
        end
        for (int i = 0; i < 2; i++) begin
            if (win >= 0 && i > win)  nc[i] = 0;
            else if (i == win)        nc[i] = d[i];
            else if (st)              nc[i] = c[i];
            else if (c[i] > 0)        nc[i] = c[i] - 1;
            else                      nc[i] = 0;
        end
        n.cnt  = {2'(nc[1]), 2'(nc[0])};
        n.drop = rq;
        if (win >= 0) n.drop[win] = 1'b0;
        if (clr)                                         n.perf = 16'd0;
        else if ((c[0] + c[1]) > 0 && !st && int'(s.perf) < pmax) n.perf = s.perf + 16'd1;
        else                                             n.perf = s.perf;
        return n;
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: advance on every edge the DUT samples and queue the expected outputs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1 = '0;
            m2 = '0;
        end else begin
            pair_t p;
            m1 = step(m1, req, stall, perf_clr, 3, 3, 65535);
            m2 = step(m2, req, stall, perf_clr, 3, 0, 3);
            p.a = m1;
            p.b = m2;
            q.push_back(p);
        end
    end

    // Monitor: after each edge, pop one expectation and compare every output of both DUTs.
    initial begin
        pair_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("cnt1",  int'(cnt1),  int'(e.a.cnt));
                chk("drop1", int'(drop1), int'(e.a.drop));
                chk("perf1", int'(perf1), int'(e.a.perf));
                chk("act1",  int'(act1),  int'({e.a.cnt[3:2] != 2'd0, e.a.cnt[1:0] != 2'd0}));
                chk("any1",  int'(any1),  int'(e.a.cnt != 4'd0));
                chk("cnt2",  int'(cnt2),  int'(e.b.cnt));
                chk("drop2", int'(drop2), int'(e.b.drop));
                chk("perf2", int'(perf2), int'(e.b.perf[1:0]));
                chk("act2",  int'(act2),  int'({e.b.cnt[3:2] != 2'd0, e.b.cnt[1:0] != 2'd0}));
                chk("any2",  int'(any2),  int'(e.b.cnt != 4'd0));
            end
        end
    end

    task automatic cyc(logic [1:0] r, logic s, logic c);
        @(negedge clk);
        req      = r;
        stall    = s;
        perf_clr = c;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) cyc(2'b00, 1'b0, 1'b0);
    endtask

    task automatic check_zero();
        chk("rst_cnt1",  int'(cnt1),  0);
        chk("rst_drop1", int'(drop1), 0);
        chk("rst_perf1", int'(perf1), 0);
        chk("rst_any1",  int'(any1),  0);
        chk("rst_cnt2",  int'(cnt2),  0);
        chk("rst_drop2", int'(drop2), 0);
        chk("rst_perf2", int'(perf2), 0);
        chk("rst_any2",  int'(any2),  0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        req = 2'b00; stall = 1'b0; perf_clr = 1'b0;
        rst = 1'b1;
        #1;
        check_zero();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_zero();
        rst = 1'b0;

        // branch alone
        cyc(2'b10, 1'b0, 1'b0);
        idle(4);
        chk("branch_perf", int'(perf1), 3);

        // stall stretch
        reset_pulse();
        cyc(2'b10, 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 1'b0);
        cyc(2'b00, 1'b1, 1'b0);
        idle(4);
        chk("stall_perf", int'(perf1), 3);

        // priority squash, simultaneous, drop while flushing
        cyc(2'b10, 1'b0, 1'b0);
        cyc(2'b01, 1'b0, 1'b0);
        idle(4);
        cyc(2'b11, 1'b0, 1'b0);
        idle(3);
        cyc(2'b01, 1'b0, 1'b0);
        idle(1);
        cyc(2'b10, 1'b0, 1'b0);
        idle(3);

        // reset mid-burst with C[1]=2
        cyc(2'b10, 1'b0, 1'b0);
        idle(1);
        reset_pulse();

        // saturation of the 2-bit counter, then clear
        cyc(2'b01, 1'b0, 1'b0);
        idle(3);
        cyc(2'b01, 1'b0, 1'b0);
        idle(4);
        chk("sat_perf2", int'(perf2), 3);
        cyc(2'b00, 1'b0, 1'b1);
        idle(1);
        chk("clr_perf2", int'(perf2), 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_pulse();
            end else begin
                cyc(($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'b00,
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 29) == 0);
            end
        end
        idle(3);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hazard_bubble_ctrl
